// File: rtl/usb_bus_arbiter.sv
// usb_bus_arbiter: two-node D+/D- line arbiter with EOP/drop release and turnaround gap; define USB_ARB_TIMEOUT_EN for the grant hold timeout
module usb_bus_arbiter #(
  parameter int FULLSPEED       = 1,
  parameter int TURNAROUND_CLKS = 2,
  parameter int MAX_HOLD_CLKS   = 4096
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [1:0] req,
  input  logic [1:0] node_oe,
  input  logic [1:0] node_dp,
  input  logic [1:0] node_dm,
  output logic [1:0] gnt,
  output logic       bus_oe,
  output logic       bus_dp,
  output logic       bus_dm,
  output logic       eop_pulse,
  output logic       timeout_err
);
  localparam logic       J_DP      = (FULLSPEED != 0);
  localparam logic       J_DM      = (FULLSPEED == 0);
  localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND_CLKS);

  if (TURNAROUND_CLKS < 1 || TURNAROUND_CLKS > 15 || MAX_HOLD_CLKS < 1 || MAX_HOLD_CLKS > 8191) begin : g_bad_param
    $error("usb_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TURN} state_t;

  state_t     state, state_nx;
  logic [3:0] turn_cnt, turn_cnt_nx;
  logic [1:0] se0_cnt, se0_cnt_nx;
  logic [1:0] req_ok;
  logic       granted, owner, own_oe, own_dp, own_dm;
  logic       se0, j_seen, eop, drop, hold_hit;
  logic       nx_gr, nx_own, nx_oe;

  assign granted = (state == GRANT0) || (state == GRANT1);
  assign owner   = (state == GRANT1);
  assign own_oe  = node_oe[owner];
  assign own_dp  = node_dp[owner];
  assign own_dm  = node_dm[owner];
  assign se0     = own_oe && !own_dp && !own_dm;
  assign j_seen  = own_oe && (own_dp == J_DP) && (own_dm == J_DM);
  assign eop     = granted && j_seen && (se0_cnt >= 2'd2);
  assign drop    = granted && !req[owner];

  assign se0_cnt_nx = !(granted && se0) ? 2'd0 : (se0_cnt == 2'd3) ? 2'd3 : se0_cnt + 2'd1;

  assign nx_gr  = (state_nx == GRANT0) || (state_nx == GRANT1);
  assign nx_own = (state_nx == GRANT1);
  assign nx_oe  = nx_gr && node_oe[nx_own];

`ifdef USB_ARB_TIMEOUT_EN
  logic [12:0] hold_cnt;
  logic [1:0]  blocked;
  logic        forced;

  assign hold_hit = granted && (hold_cnt == 13'(MAX_HOLD_CLKS - 1));
  assign forced   = hold_hit && !eop && !drop;
  assign req_ok   = req & ~blocked;

  // hold counter, timeout pulse, and lockout until the timed-out node drops its request
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hold_cnt    <= 13'd0;
      blocked     <= 2'b00;
      timeout_err <= 1'b0;
    end else begin
      hold_cnt    <= granted ? hold_cnt + 13'd1 : 13'd0;
      timeout_err <= forced;
      blocked     <= (blocked & req) | ({owner, !owner} & {2{forced}});
    end
  end
`else
  assign hold_hit    = 1'b0;
  assign req_ok      = req;
  assign timeout_err = 1'b0;
`endif

  // next-state logic: fixed priority to node 0, release into a counted turnaround
  always_comb begin
    state_nx    = state;
    turn_cnt_nx = turn_cnt;
    case (state)
      IDLE: state_nx = req_ok[0] ? GRANT0 : req_ok[1] ? GRANT1 : IDLE;
      GRANT0, GRANT1: begin
        if (eop || drop || hold_hit) begin
          state_nx    = TURN;
          turn_cnt_nx = TURN_LOAD;
        end
      end
      TURN: begin
        turn_cnt_nx = turn_cnt - 4'd1;
        state_nx    = (turn_cnt == 4'd1) ? IDLE : TURN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state, SE0 tracking and registered outputs driven from the next owner
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      turn_cnt  <= 4'd0;
      se0_cnt   <= 2'd0;
      gnt       <= 2'b00;
      bus_oe    <= 1'b0;
      bus_dp    <= J_DP;
      bus_dm    <= J_DM;
      eop_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      turn_cnt  <= turn_cnt_nx;
      se0_cnt   <= se0_cnt_nx;
      gnt       <= {state_nx == GRANT1, state_nx == GRANT0};
      bus_oe    <= nx_oe;
      bus_dp    <= nx_oe ? node_dp[nx_own] : J_DP;
      bus_dm    <= nx_oe ? node_dm[nx_own] : J_DM;
      eop_pulse <= eop;
    end
  end
endmodule

// File: tb/tb_usb_bus_arbiter.sv
// tb_usb_bus_arbiter: directed self-checking bench for usb_bus_arbiter (full speed, turnaround 2, hold limit 16)
module tb_usb_bus_arbiter;
  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] node_oe = 2'b00;
  logic [1:0] node_dp = 2'b00;
  logic [1:0] node_dm = 2'b00;
  logic [1:0] gnt;
  logic       bus_oe, bus_dp, bus_dm, eop_pulse, timeout_err;
  logic [6:0] obs;
  int         n_cmp = 0;
  int         n_err = 0;

  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;
  localparam logic [6:0] QUIET = 7'b00_0_10_0_0;
  localparam logic [6:0] EOPO  = 7'b00_0_10_1_0;

  usb_bus_arbiter #(.FULLSPEED(1), .TURNAROUND_CLKS(2), .MAX_HOLD_CLKS(16)) dut (
    .clk(clk), .nreset(nreset), .req(req), .node_oe(node_oe), .node_dp(node_dp),
    .node_dm(node_dm), .gnt(gnt), .bus_oe(bus_oe), .bus_dp(bus_dp), .bus_dm(bus_dm),
    .eop_pulse(eop_pulse), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  assign obs = {gnt, bus_oe, bus_dp, bus_dm, eop_pulse, timeout_err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nd(input int n, input logic o, input logic [1:0] v);
    node_oe[n] = o;
    node_dp[n] = v[1];
    node_dm[n] = v[0];
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed={gnt,oe,dp,dm,eop,to}=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    tick(); tick();
    chk("reset_state", QUIET);
    nreset = 1'b1;
    tick();
    chk("idle_no_req", QUIET);

    req = 2'b11; nd(0, 1'b1, K); nd(1, 1'b0, SE0);
    tick(); chk("simul_req_node0_wins", 7'b01_1_01_0_0);
    nd(0, 1'b1, J);
    tick(); chk("n0_j", 7'b01_1_10_0_0);
    nd(0, 1'b1, SE0);
    tick(); chk("n0_se0_a", 7'b01_1_00_0_0);
    tick(); chk("n0_se0_b", 7'b01_1_00_0_0);
    nd(0, 1'b1, J);
    tick(); chk("n0_eop", EOPO);
    req = 2'b10; nd(0, 1'b0, J);
    tick(); chk("turn_1", QUIET);
    tick(); chk("turn_2_to_idle", QUIET);
    tick(); chk("grant1_after_turn", 7'b10_0_10_0_0);

    nd(1, 1'b1, K); nd(0, 1'b1, 2'b11);
    tick(); chk("mux_01", 7'b10_1_01_0_0);
    nd(1, 1'b1, J); nd(0, 1'b1, SE0);
    tick(); chk("mux_10", 7'b10_1_10_0_0);
    nd(1, 1'b1, K); nd(0, 1'b1, J);
    tick(); chk("mux_01b", 7'b10_1_01_0_0);
    nd(0, 1'b0, J);

    nd(1, 1'b1, SE0);
    tick(); chk("single_se0", 7'b10_1_00_0_0);
    nd(1, 1'b1, J);
    tick(); chk("single_se0_then_j_no_eop", 7'b10_1_10_0_0);
    nd(1, 1'b1, SE0);
    tick(); chk("se0k_a", 7'b10_1_00_0_0);
    tick(); chk("se0k_b", 7'b10_1_00_0_0);
    nd(1, 1'b1, K);
    tick(); chk("se0_se0_k_no_eop", 7'b10_1_01_0_0);
    nd(1, 1'b1, J);
    tick(); chk("k_clears_se0_cnt", 7'b10_1_10_0_0);

    nd(1, 1'b1, SE0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("se0_sat", 7'b10_1_00_0_0);
    end
    nd(1, 1'b1, J);
    tick(); chk("sat_se0_eop", EOPO);
    req = 2'b01; nd(0, 1'b1, J); nd(1, 1'b0, J);
    tick(); chk("turn_b1", QUIET);
    tick(); chk("turn_b2", QUIET);
    tick(); chk("grant0_again", 7'b01_1_10_0_0);

    req = 2'b11;
    tick(); chk("pending_n1_no_switch", 7'b01_1_10_0_0);
    req = 2'b10; nd(1, 1'b1, J);
    tick(); chk("req_drop_release", QUIET);
    tick(); chk("drop_turn_1", QUIET);
    tick(); chk("drop_turn_2", QUIET);
    tick(); chk("pending_n1_granted", 7'b10_1_10_0_0);

`ifdef USB_ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      tick(); chk("hold_before_timeout", 7'b10_1_10_0_0);
    end
    tick(); chk("timeout_pulse", 7'b00_0_10_0_1);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("blocked_until_rereq", QUIET);
    end
    req = 2'b00;
    tick(); chk("rereq_drop", QUIET);
    req = 2'b10;
    tick(); chk("rereq_granted", 7'b10_1_10_0_0);
`else
    for (int i = 0; i < 110; i++) begin
      tick(); chk("no_timeout_hold", 7'b10_1_10_0_0);
    end
`endif

    #2;
    nreset = 1'b0;
    #1;
    chk("async_reset_mid_grant", QUIET);
    req = 2'b00;
    tick();
    nreset = 1'b1;
    tick(); chk("post_reset_idle", QUIET);
    req = 2'b01;
    tick(); chk("post_reset_grant", 7'b01_1_10_0_0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
